// File: rtl/fetch_redirect_ctrl_if.sv
// Predictor write-port bundle between the fetch redirect controller and
// the branch/JALR predictor update logic.
//
// Signals:
//   upd_valid_o    head entry of the update FIFO is valid
//   upd_ready_i    predictor accepts the head entry this cycle
//   upd_is_jalr_o  0 = branch predictor, 1 = JALR predictor
//   upd_pc_o       lookup PC of the prediction being trained
//   upd_target_o   resolved target
//   upd_history_o  history snapshot used for the lookup
interface fetch_redirect_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int HIST_WIDTH = 6
);
    logic                  upd_valid_o;
    logic                  upd_ready_i;
    logic                  upd_is_jalr_o;
    logic [DATA_WIDTH-1:0] upd_pc_o;
    logic [DATA_WIDTH-1:0] upd_target_o;
    logic [HIST_WIDTH-1:0] upd_history_o;

    modport master (
        output upd_valid_o,
        output upd_is_jalr_o,
        output upd_pc_o,
        output upd_target_o,
        output upd_history_o,
        input  upd_ready_i
    );

    modport slave (
        input  upd_valid_o,
        input  upd_is_jalr_o,
        input  upd_pc_o,
        input  upd_target_o,
        input  upd_history_o,
        output upd_ready_i
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch recovery sequencer: arbitrates three mispredict reports into one
// registered redirect/flush/RAS-restore event, holds fetch for a fixed
// recovery window, and serializes up to three predictor updates per cycle
// through a FIFO onto the single predictor write port.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   misprediction_i_k/correct_pc_i_k   mispredict reports (slot 0 oldest)
//   update_valid_i_k, is_jalr_i_k,
//   pc_at_prediction_i_k,
//   update_global_history_k        predictor update requests
//   ras_restore_en_i/tos_i         RAS restore request
//   upd (master)                   predictor write port (FIFO head)
//   flush_o, redirect_valid_o,
//   redirect_pc_o, fetch_hold_o    fetch/buffer recovery controls
//   ras_restore_en_o/tos_o         registered RAS restore
//   upd_count_o, upd_overflow_o    FIFO occupancy, dropped-update pulse
module fetch_redirect_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int ENTRIES         = 32,
    parameter int INDEX_WIDTH     = $clog2(ENTRIES),
    parameter int UPD_DEPTH       = 8,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     misprediction_i_0,
    input  logic                     misprediction_i_1,
    input  logic                     misprediction_i_2,
    input  logic [DATA_WIDTH-1:0]    correct_pc_i_0,
    input  logic [DATA_WIDTH-1:0]    correct_pc_i_1,
    input  logic [DATA_WIDTH-1:0]    correct_pc_i_2,
    input  logic                     update_valid_i_0,
    input  logic                     update_valid_i_1,
    input  logic                     update_valid_i_2,
    input  logic                     is_jalr_i_0,
    input  logic                     is_jalr_i_1,
    input  logic                     is_jalr_i_2,
    input  logic [DATA_WIDTH-1:0]    pc_at_prediction_i_0,
    input  logic [DATA_WIDTH-1:0]    pc_at_prediction_i_1,
    input  logic [DATA_WIDTH-1:0]    pc_at_prediction_i_2,
    input  logic [INDEX_WIDTH:0]     update_global_history_0,
    input  logic [INDEX_WIDTH:0]     update_global_history_1,
    input  logic [INDEX_WIDTH:0]     update_global_history_2,
    input  logic                     ras_restore_en_i,
    input  logic [2:0]               ras_restore_tos_i,
    fetch_redirect_ctrl_if.master    upd,
    output logic                     flush_o,
    output logic                     redirect_valid_o,
    output logic [DATA_WIDTH-1:0]    redirect_pc_o,
    output logic                     fetch_hold_o,
    output logic                     ras_restore_en_o,
    output logic [2:0]               ras_restore_tos_o,
    output logic [$clog2(UPD_DEPTH):0] upd_count_o,
    output logic                     upd_overflow_o
);

    localparam int HW  = INDEX_WIDTH + 1;
    localparam int PW  = $clog2(UPD_DEPTH);
    localparam int CW  = PW + 1;
    localparam int RCW = $clog2(RECOVERY_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_RECOVER
    } state_e;

    typedef struct packed {
        logic                  is_jalr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] target;
        logic [HW-1:0]         hist;
    } upd_t;

    // ---------------- redirect arbitration ----------------
    logic [2:0]            mis;
    logic                  mis_any;
    logic [DATA_WIDTH-1:0] sel_pc;

    assign mis = {misprediction_i_2, misprediction_i_1, misprediction_i_0};
    assign mis_any = |mis;

    // Oldest slot wins.
    always_comb begin
        sel_pc = correct_pc_i_0;
        priority case (1'b1)
            mis[0]:  sel_pc = correct_pc_i_0;
            mis[1]:  sel_pc = correct_pc_i_1;
            mis[2]:  sel_pc = correct_pc_i_2;
            default: sel_pc = correct_pc_i_0;
        endcase
    end

    // ---------------- recovery FSM ----------------
    state_e                state_q, state_d;
    logic [RCW-1:0]        rcnt_q, rcnt_d;
    logic [DATA_WIDTH-1:0] rpc_q, rpc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            rpc_q   <= rpc_d;
        end
    end

    // A new mispredict in any state restarts the sequence.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rpc_d   = rpc_q;
        if (mis_any) begin
            state_d = S_FLUSH;
            rpc_d   = sel_pc;
        end else begin
            unique case (state_q)
                S_FLUSH: begin
                    state_d = S_RECOVER;
                    rcnt_d  = RCW'(RECOVERY_CYCLES - 1);
                end
                S_RECOVER: begin
                    if (rcnt_q == '0) state_d = S_IDLE;
                    else              rcnt_d  = rcnt_q - RCW'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        fetch_hold_o     = 1'b0;
        unique case (state_q)
            S_FLUSH: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                fetch_hold_o     = 1'b1;
            end
            S_RECOVER: fetch_hold_o = 1'b1;
            default: ;
        endcase
    end

    assign redirect_pc_o = rpc_q;

    // ---------------- RAS restore ----------------
    logic       ras_en_q;
    logic [2:0] ras_tos_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_en_q  <= 1'b0;
            ras_tos_q <= '0;
        end else begin
            ras_en_q <= ras_restore_en_i;
            if (ras_restore_en_i) ras_tos_q <= ras_restore_tos_i;
        end
    end

    assign ras_restore_en_o  = ras_en_q;
    assign ras_restore_tos_o = ras_tos_q;

    // ---------------- update FIFO ----------------
    upd_t           ent [3];
    logic [2:0]     uv;
    upd_t           mem_q [UPD_DEPTH];
    logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]  fcnt_q, fcnt_d;
    logic           ovf_q;
    logic           pop;
    logic [CW-1:0]  free;
    logic [CW-1:0]  acc;
    logic           drop;
    logic [2:0]     we;
    logic [PW-1:0]  wa [3];

    assign uv = {update_valid_i_2, update_valid_i_1, update_valid_i_0};
    assign ent[0] = '{is_jalr_i_0, pc_at_prediction_i_0,
                      correct_pc_i_0, update_global_history_0};
    assign ent[1] = '{is_jalr_i_1, pc_at_prediction_i_1,
                      correct_pc_i_1, update_global_history_1};
    assign ent[2] = '{is_jalr_i_2, pc_at_prediction_i_2,
                      correct_pc_i_2, update_global_history_2};

    assign pop  = (fcnt_q != '0) & upd.upd_ready_i;
    // A same-cycle pop frees a slot for this cycle's pushes.
    assign free = CW'(UPD_DEPTH) - fcnt_q + CW'(pop);

    // Lowest-index valid slots fill the free space; the rest are dropped.
    always_comb begin
        acc  = '0;
        drop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b0;
            wa[k] = wr_q;
            if (uv[k]) begin
                if (acc < free) begin
                    we[k] = 1'b1;
                    wa[k] = wr_q + acc[PW-1:0];
                    acc   = acc + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    assign fcnt_d = fcnt_q - CW'(pop) + acc;
    assign rd_d   = rd_q + PW'(pop);
    assign wr_d   = wr_q + acc[PW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            fcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            fcnt_q <= fcnt_d;
            ovf_q  <= drop;
        end
    end

    // Storage needs no reset: head outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (we[k]) mem_q[wa[k]] <= ent[k];
        end
    end

    upd_t head;
    logic hv;

    assign hv   = (fcnt_q != '0);
    assign head = hv ? mem_q[rd_q] : '0;

    assign upd.upd_valid_o   = hv;
    assign upd.upd_is_jalr_o = head.is_jalr;
    assign upd.upd_pc_o      = head.pc;
    assign upd.upd_target_o  = head.target;
    assign upd.upd_history_o = head.hist;
    assign upd_count_o       = fcnt_q;
    assign upd_overflow_o    = ovf_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed vector table,
// hand-written FIFO/reset sequences, and random traffic against a model.
module tb_fetch_redirect_ctrl;

    localparam int DW    = 32;
    localparam int HW    = 6;
    localparam int DEPTH = 8;
    localparam int RC    = 2;

    logic clk = 1'b0;
    logic reset;
    logic [2:0]    mis, uv, jalr;
    logic [DW-1:0] cpc [3];
    logic [DW-1:0] ppc [3];
    logic [HW-1:0] hist [3];
    logic          ras_en;
    logic [2:0]    tos;

    logic          flush_o, rv_o, hold_o, ras_en_o, ovf_o;
    logic [DW-1:0] rpc_o;
    logic [2:0]    tos_o;
    logic [3:0]    cnt_o;

    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.DATA_WIDTH(DW), .HIST_WIDTH(HW)) u_if ();

    fetch_redirect_ctrl #(
        .DATA_WIDTH(DW), .ENTRIES(32), .UPD_DEPTH(DEPTH),
        .RECOVERY_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset),
        .misprediction_i_0(mis[0]), .misprediction_i_1(mis[1]),
        .misprediction_i_2(mis[2]),
        .correct_pc_i_0(cpc[0]), .correct_pc_i_1(cpc[1]),
        .correct_pc_i_2(cpc[2]),
        .update_valid_i_0(uv[0]), .update_valid_i_1(uv[1]),
        .update_valid_i_2(uv[2]),
        .is_jalr_i_0(jalr[0]), .is_jalr_i_1(jalr[1]), .is_jalr_i_2(jalr[2]),
        .pc_at_prediction_i_0(ppc[0]), .pc_at_prediction_i_1(ppc[1]),
        .pc_at_prediction_i_2(ppc[2]),
        .update_global_history_0(hist[0]), .update_global_history_1(hist[1]),
        .update_global_history_2(hist[2]),
        .ras_restore_en_i(ras_en), .ras_restore_tos_i(tos),
        .upd(u_if),
        .flush_o(flush_o), .redirect_valid_o(rv_o), .redirect_pc_o(rpc_o),
        .fetch_hold_o(hold_o), .ras_restore_en_o(ras_en_o),
        .ras_restore_tos_o(tos_o), .upd_count_o(cnt_o),
        .upd_overflow_o(ovf_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        mis = '0; uv = '0; ras_en = 1'b0; tos = '0;
        for (int k = 0; k < 3; k++) begin
            cpc[k] = '0;
            ppc[k] = DW'(32'h1000 + 4 * k);
            hist[k] = HW'(k + 1);
        end
        jalr = 3'b010;
    endtask

    task automatic set_upd(input logic [2:0] v, input logic [DW-1:0] base);
        uv = v;
        for (int k = 0; k < 3; k++) cpc[k] = base + DW'(k);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]    mis;
        logic [DW-1:0] c0, c1, c2;
        logic [2:0]    uv;
        logic          rdy, ras;
        logic [2:0]    tos;
        logic          e_flush, e_hold;
        logic [DW-1:0] e_pc;
        logic          e_ras;
        logic [3:0]    e_cnt;
        logic [DW-1:0] e_tgt;
        logic          e_jalr;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(
        logic [2:0] m, logic [DW-1:0] c0, logic [DW-1:0] c1,
        logic [DW-1:0] c2, logic [2:0] v, logic r, logic re,
        logic [2:0] t, logic ef, logic eh, logic [DW-1:0] ep,
        logic er, logic [3:0] ec, logic [DW-1:0] et, logic ej);
        vec_t x;
        x.mis = m; x.c0 = c0; x.c1 = c1; x.c2 = c2; x.uv = v;
        x.rdy = r; x.ras = re; x.tos = t; x.e_flush = ef; x.e_hold = eh;
        x.e_pc = ep; x.e_ras = er; x.e_cnt = ec; x.e_tgt = et; x.e_jalr = ej;
        return x;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic          j;
        logic [DW-1:0] pc, tgt;
        logic [HW-1:0] h;
    } ent_t;

    ent_t          q [$];
    bit            m_flush;
    int            m_hold;
    logic [DW-1:0] m_pc;
    bit            m_ras;
    logic [2:0]    m_tos;
    bit            m_ovf;

    task automatic model_reset();
        q.delete();
        m_flush = 0; m_hold = 0; m_pc = '0;
        m_ras = 0; m_tos = '0; m_ovf = 0;
    endtask

    // Evaluated with the inputs about to be sampled at the next edge.
    task automatic model_step();
        bit found;
        ent_t e;
        if (q.size() > 0 && u_if.upd_ready_i) void'(q.pop_front());
        m_ovf = 0;
        for (int k = 0; k < 3; k++) begin
            if (uv[k]) begin
                if (q.size() < DEPTH) begin
                    e.j = jalr[k]; e.pc = ppc[k]; e.tgt = cpc[k]; e.h = hist[k];
                    q.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        found = 0;
        for (int k = 0; k < 3; k++) begin
            if (mis[k] && !found) begin
                m_pc = cpc[k];
                found = 1;
            end
        end
        if (found) begin
            m_flush = 1;
            m_hold  = RC;
        end else if (m_flush) begin
            m_flush = 0;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        m_ras = ras_en;
        if (ras_en) m_tos = tos;
    endtask

    task automatic cmp_model();
        chk("rnd_flush", flush_o, m_flush);
        chk("rnd_rv", rv_o, m_flush);
        chk("rnd_hold", hold_o, m_flush || m_hold > 0);
        if (m_flush) chk("rnd_pc", rpc_o, m_pc);
        chk("rnd_ras", ras_en_o, m_ras);
        if (m_ras) chk("rnd_tos", tos_o, m_tos);
        chk("rnd_cnt", cnt_o, q.size());
        chk("rnd_valid", u_if.upd_valid_o, q.size() > 0);
        chk("rnd_ovf", ovf_o, m_ovf);
        if (q.size() > 0) begin
            chk("rnd_hjalr", u_if.upd_is_jalr_o, q[0].j);
            chk("rnd_hpc", u_if.upd_pc_o, q[0].pc);
            chk("rnd_htgt", u_if.upd_target_o, q[0].tgt);
            chk("rnd_hhist", u_if.upd_history_o, q[0].h);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_flush"}, flush_o, 0);
        chk({nm, "_rv"}, rv_o, 0);
        chk({nm, "_hold"}, hold_o, 0);
        chk({nm, "_pc"}, rpc_o, 0);
        chk({nm, "_ras"}, ras_en_o, 0);
        chk({nm, "_tos"}, tos_o, 0);
        chk({nm, "_cnt"}, cnt_o, 0);
        chk({nm, "_valid"}, u_if.upd_valid_o, 0);
        chk({nm, "_ovf"}, ovf_o, 0);
        chk({nm, "_hpc"}, u_if.upd_pc_o, 0);
        chk({nm, "_htgt"}, u_if.upd_target_o, 0);
        chk({nm, "_hjalr"}, u_if.upd_is_jalr_o, 0);
        chk({nm, "_hhist"}, u_if.upd_history_o, 0);
    endtask

    initial begin
        tbl[0]  = mk(3'b110, 0, 32'h100, 32'h200, 0, 0, 1, 5,
                     1, 1, 32'h100, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0);
        tbl[4]  = mk(3'b001, 32'h40, 0, 0, 0, 0, 0, 0,
                     1, 1, 32'h40, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
        tbl[6]  = mk(3'b100, 0, 0, 32'h80, 0, 0, 0, 0,
                     1, 1, 32'h80, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0, 0, 0);
        tbl[10] = mk(0, 32'hA0, 32'hB0, 32'hC0, 3'b111, 0, 0, 0,
                     0, 0, 32'h80, 0, 3, 32'hA0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h80, 0, 2, 32'hB0, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h80, 0, 1, 32'hC0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h80, 0, 0, 0, 0);

        clear_in();
        u_if.upd_ready_i = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("idle_hold", hold_o, 0);
        chk("idle_cnt", cnt_o, 0);

        for (int i = 0; i < 14; i++) begin
            mis = tbl[i].mis;
            cpc[0] = tbl[i].c0; cpc[1] = tbl[i].c1; cpc[2] = tbl[i].c2;
            uv = tbl[i].uv;
            u_if.upd_ready_i = tbl[i].rdy;
            ras_en = tbl[i].ras; tos = tbl[i].tos;
            tick();
            chk($sformatf("t%0d_flush", i), flush_o, tbl[i].e_flush);
            chk($sformatf("t%0d_rv", i), rv_o, tbl[i].e_flush);
            chk($sformatf("t%0d_hold", i), hold_o, tbl[i].e_hold);
            chk($sformatf("t%0d_pc", i), rpc_o, tbl[i].e_pc);
            chk($sformatf("t%0d_ras", i), ras_en_o, tbl[i].e_ras);
            if (tbl[i].e_ras) chk($sformatf("t%0d_tos", i), tos_o, tbl[i].tos);
            chk($sformatf("t%0d_cnt", i), cnt_o, tbl[i].e_cnt);
            chk($sformatf("t%0d_ovf", i), ovf_o, 0);
            if (tbl[i].e_cnt != 0) begin
                chk($sformatf("t%0d_htgt", i), u_if.upd_target_o, tbl[i].e_tgt);
                chk($sformatf("t%0d_hjalr", i), u_if.upd_is_jalr_o,
                    tbl[i].e_jalr);
            end
        end

        // Fill to 7, then three arrive with no pop: only slot 0 fits.
        clear_in();
        u_if.upd_ready_i = 1'b0;
        set_upd(3'b111, 32'h10); tick();
        set_upd(3'b111, 32'h20); tick();
        set_upd(3'b001, 32'h30); tick();
        chk("fill7_cnt", cnt_o, 7);
        chk("fill7_ovf", ovf_o, 0);
        set_upd(3'b111, 32'h40); tick();
        chk("ovf_cnt", cnt_o, 8);
        chk("ovf_pulse", ovf_o, 1);
        chk("ovf_head", u_if.upd_target_o, 32'h10);
        uv = '0; tick();
        chk("ovf_once", ovf_o, 0);
        chk("ovf_hold_cnt", cnt_o, 8);

        // Full with simultaneous pop and single push.
        u_if.upd_ready_i = 1'b1;
        set_upd(3'b001, 32'h50); tick();
        chk("full_pp_cnt", cnt_o, 8);
        chk("full_pp_ovf", ovf_o, 0);
        chk("full_pp_head", u_if.upd_target_o, 32'h11);

        // Drain to 5, enter FLUSH, then reset mid-cycle.
        uv = '0;
        repeat (3) tick();
        chk("drain5_cnt", cnt_o, 5);
        chk("drain5_head", u_if.upd_target_o, 32'h21);
        u_if.upd_ready_i = 1'b0;
        mis = 3'b001; cpc[0] = 32'h300; ras_en = 1'b1; tos = 3'd6;
        tick();
        chk("pre_rst_flush", flush_o, 1);
        chk("pre_rst_cnt", cnt_o, 5);
        chk("pre_rst_ras", ras_en_o, 1);
        reset = 1'b1;
        clear_in();
        #2;
        chk_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_hold", hold_o, 0);
        chk("post_rst_flush", flush_o, 0);
        chk("post_rst_cnt", cnt_o, 0);
        chk("post_rst_valid", u_if.upd_valid_o, 0);

        // Random traffic against the model.
        model_reset();
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < 3; k++) begin
                mis[k]  = ($urandom_range(0, 9) == 0);
                uv[k]   = $urandom_range(0, 1);
                jalr[k] = $urandom_range(0, 1);
                cpc[k]  = $urandom;
                ppc[k]  = $urandom;
                hist[k] = HW'($urandom);
            end
            ras_en = ($urandom_range(0, 3) == 0);
            tos    = 3'($urandom);
            u_if.upd_ready_i = ($urandom_range(0, 2) == 0);
            model_step();
            tick();
            cmp_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
